// File: rtl/fetch_pc_nested.sv
// Fetch PC unit: selects the next IF address from sequential, branch, redirect,
// interrupt and return sources, with a saved-PC stack for nested interrupts.
module fetch_pc_nested #(
  parameter int unsigned        ADDR_W     = 32,
  parameter int unsigned        INC        = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'('h100),
  parameter logic [ADDR_W-1:0]  VEC_STRIDE = ADDR_W'('h10),
  parameter int unsigned        NUM_IRQ    = 4,
  parameter int unsigned        NEST_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              stall,
  input  logic [NUM_IRQ-1:0]                alert,
  input  logic                              branch_predict,
  input  logic                              branch_undo,
  input  logic                              pcr_take,
  input  logic                              pci_take,
  input  logic [ADDR_W-1:0]                 branch_pc,
  input  logic [ADDR_W-1:0]                 pc_not_taken,
  input  logic [ADDR_W-1:0]                 pcr,
  output logic [ADDR_W-1:0]                 mem_addr,
  output logic [ADDR_W-1:0]                 pc_plus_inc,
  output logic                              interrupt,
  output logic [NUM_IRQ-1:0]                irq_ack,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level,
  output logic                              interrupt_mask,
  output logic                              flush,
  output logic                              stack_err
);

  localparam int unsigned LVL_W = $clog2(NEST_DEPTH + 1);
  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned SP_W  = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] vec_pc;
  logic [ADDR_W-1:0] push_val;
  logic [ADDR_W-1:0] stack_top;
  logic [ADDR_W-1:0] pc_next;
  logic [IDX_W-1:0]  irq_idx;
  logic              stack_empty;
  logic              pop;
  logic              err_set;
  logic [ADDR_W-1:0] stack_mem [NEST_DEPTH];

  assign pc_inc         = pc + ADDR_W'(INC);
  assign pc_plus_inc    = pc_inc;
  assign seq_pc         = stall ? pc : pc_inc;
  assign interrupt_mask = (nest_level == LVL_W'(NEST_DEPTH));
  assign stack_empty    = (nest_level == '0);
  assign stack_top      = stack_mem[SP_W'(nest_level - LVL_W'(1))];

  // Lowest-numbered pending line wins.
  always_comb begin
    irq_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (alert[i]) irq_idx = IDX_W'(i);
    end
  end

  assign interrupt = (|alert) & ~interrupt_mask & ~stall &
                     ~branch_undo & ~pcr_take & ~pci_take;
  assign irq_ack   = interrupt ? (NUM_IRQ'(1) << irq_idx) : '0;
  assign vec_pc    = VEC_BASE + ADDR_W'(irq_idx) * VEC_STRIDE;
  // Return address is where fetch would have gone had the interrupt not hit.
  assign push_val  = branch_predict ? branch_pc : pc_inc;
  assign flush     = branch_undo | pcr_take | pci_take | interrupt;
  assign pop       = pci_take & ~branch_undo & ~pcr_take & ~stack_empty;
  assign err_set   = pci_take & ~branch_undo & ~pcr_take & stack_empty;

  always_comb begin
    pc_next = seq_pc;
    if (branch_undo)                 pc_next = pc_not_taken;
    else if (pcr_take)               pc_next = pcr;
    else if (pci_take)               pc_next = stack_empty ? RESET_PC : stack_top;
    else if (interrupt)              pc_next = vec_pc;
    else if (branch_predict && !stall) pc_next = branch_pc;
  end

  assign mem_addr = pc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      nest_level <= '0;
      stack_err  <= 1'b0;
    end else begin
      pc <= pc_next;
      if (interrupt)    nest_level <= nest_level + LVL_W'(1);
      else if (pop)     nest_level <= nest_level - LVL_W'(1);
      if (err_set)      stack_err  <= 1'b1;
    end
  end

  // Stack contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (interrupt) stack_mem[SP_W'(nest_level)] <= push_val;
  end

endmodule

// File: tb/tb_fetch_pc_nested.sv
// Scoreboard bench for fetch_pc_nested: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_pc_nested;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall, branch_predict, branch_undo, pcr_take, pci_take;
  logic [3:0]  alert;
  logic [31:0] branch_pc, pc_not_taken, pcr;
  logic [31:0] mem_addr, pc_plus_inc;
  logic        interrupt, interrupt_mask, flush, stack_err;
  logic [3:0]  irq_ack;
  logic [2:0]  nest_level;

  fetch_pc_nested dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .alert(alert),
    .branch_predict(branch_predict), .branch_undo(branch_undo),
    .pcr_take(pcr_take), .pci_take(pci_take), .branch_pc(branch_pc),
    .pc_not_taken(pc_not_taken), .pcr(pcr), .mem_addr(mem_addr),
    .pc_plus_inc(pc_plus_inc), .interrupt(interrupt), .irq_ack(irq_ack),
    .nest_level(nest_level), .interrupt_mask(interrupt_mask),
    .flush(flush), .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] mem_addr;
    logic [31:0] ppi;
    logic        intr;
    logic [3:0]  ack;
    logic [2:0]  lvl;
    logic        mask;
    logic        flush;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          pushes = 0;
  int          pops = 0;

  // Reference model: PC, a queue used as the return stack, sticky error flag.
  logic [31:0] m_pc;
  logic [31:0] m_stack[$];
  logic        m_err;
  logic [31:0] m_next, m_pushval;
  logic        m_push, m_pop, m_seterr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_eval(output exp_t e);
    int idx;
    idx = -1;
    for (int i = 0; i < 4; i++) if (alert[i] && idx < 0) idx = i;
    e.ppi   = m_pc + 32'd4;
    e.lvl   = 3'(m_stack.size());
    e.mask  = (m_stack.size() == 4);
    e.intr  = (idx >= 0) && !e.mask && !stall && !branch_undo && !pcr_take && !pci_take;
    e.ack   = e.intr ? 4'(1 << idx) : 4'b0;
    e.flush = branch_undo | pcr_take | pci_take | e.intr;
    e.err   = m_err;
    m_push = 1'b0; m_pop = 1'b0; m_seterr = 1'b0; m_pushval = '0;
    if (branch_undo) m_next = pc_not_taken;
    else if (pcr_take) m_next = pcr;
    else if (pci_take) begin
      if (m_stack.size() == 0) begin m_next = 32'h0; m_seterr = 1'b1; end
      else begin m_next = m_stack[$]; m_pop = 1'b1; end
    end else if (e.intr) begin
      m_next    = 32'h100 + 32'(idx) * 32'h10;
      m_push    = 1'b1;
      m_pushval = branch_predict ? branch_pc : m_pc + 32'd4;
    end else if (branch_predict && !stall) m_next = branch_pc;
    else m_next = stall ? m_pc : m_pc + 32'd4;
    e.mem_addr = m_next;
  endtask

  task automatic drive(input logic st, input logic [3:0] al, input logic bp,
                       input logic bu, input logic pr, input logic pi,
                       input logic [31:0] bpc, input logic [31:0] pnt,
                       input logic [31:0] pra);
    exp_t e;
    stall = st; alert = al; branch_predict = bp; branch_undo = bu;
    pcr_take = pr; pci_take = pi; branch_pc = bpc; pc_not_taken = pnt; pcr = pra;
    model_eval(e);
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic cyc();
    @(posedge clk);
    m_pc = m_next;
    if (m_push) m_stack.push_back(m_pushval);
    if (m_pop) void'(m_stack.pop_back());
    if (m_seterr) m_err = 1'b1;
    #1;
  endtask

  task automatic idle();
    drive(0, 4'b0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    cyc();
  endtask

  task automatic do_reset();
    stall = 0; alert = '0; branch_predict = 0; branch_undo = 0;
    pcr_take = 0; pci_take = 0; branch_pc = '0; pc_not_taken = '0; pcr = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_nest_level", 32'(nest_level), 32'h0);
    chk("rst_stack_err", 32'(stack_err), 32'h0);
    chk("rst_pc_plus_inc", pc_plus_inc, 32'h4);
    chk("rst_mem_addr", mem_addr, 32'h4);
    chk("rst_interrupt", 32'(interrupt), 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    m_pc = 32'h0; m_stack.delete(); m_err = 1'b0;
  endtask

  // Monitor: each cycle's outputs are compared against the queued expectation.
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      pops++;
      chk("sb_mem_addr", mem_addr, mon_e.mem_addr);
      chk("sb_pc_plus_inc", pc_plus_inc, mon_e.ppi);
      chk("sb_interrupt", 32'(interrupt), 32'(mon_e.intr));
      chk("sb_irq_ack", 32'(irq_ack), 32'(mon_e.ack));
      chk("sb_nest_level", 32'(nest_level), 32'(mon_e.lvl));
      chk("sb_mask", 32'(interrupt_mask), 32'(mon_e.mask));
      chk("sb_flush", 32'(flush), 32'(mon_e.flush));
      chk("sb_stack_err", 32'(stack_err), 32'(mon_e.err));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lifo [4];
    logic [3:0]  al;
    logic [31:0] a0, a1, a2;
    lifo[0] = 32'h124; lifo[1] = 32'h114; lifo[2] = 32'h104; lifo[3] = 32'h28;

    #2;
    do_reset();

    // T1: sequential fetch from reset
    drive(0, 4'b0, 0, 0, 0, 0, 0, 0, 0); #1 chk("t1_addr0", mem_addr, 32'h4); cyc();
    drive(0, 4'b0, 0, 0, 0, 0, 0, 0, 0); #1 chk("t1_addr1", mem_addr, 32'h8); cyc();
    drive(0, 4'b0, 0, 0, 0, 0, 0, 0, 0); #1 chk("t1_addr2", mem_addr, 32'hC); cyc();

    // T2: interrupt from PC 0x20 then return
    drive(0, 4'b0, 0, 0, 1, 0, 0, 0, 32'h20); cyc();
    drive(0, 4'b0110, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("t2_mem_addr", mem_addr, 32'h110);
    chk("t2_irq_ack", 32'(irq_ack), 32'h2);
    chk("t2_interrupt", 32'(interrupt), 32'h1);
    chk("t2_flush", 32'(flush), 32'h1);
    cyc();
    chk("t2_nest1", 32'(nest_level), 32'h1);
    drive(0, 4'b0, 0, 0, 0, 1, 0, 0, 0); #1 chk("t2_ret", mem_addr, 32'h24); cyc();
    chk("t2_nest0", 32'(nest_level), 32'h0);

    // T3: fill the stack, confirm masking, unwind in LIFO order
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'(1 << i), 0, 0, 0, 0, 0, 0, 0); cyc();
    end
    drive(0, 4'b1111, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("t3_mask", 32'(interrupt_mask), 32'h1);
    chk("t3_no_irq", 32'(interrupt), 32'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 4'b0, 0, 0, 0, 1, 0, 0, 0); #1 chk("t3_lifo", mem_addr, lifo[i]); cyc();
    end

    // T4: mispredict outranks irq and predict; irq follows next cycle
    drive(0, 4'b0001, 1, 1, 0, 0, 32'h500, 32'h80, 0); #1;
    chk("t4_undo", mem_addr, 32'h80);
    chk("t4_no_irq", 32'(interrupt), 32'h0);
    cyc();
    drive(0, 4'b0001, 0, 0, 0, 0, 0, 0, 0); #1 chk("t4_irq", mem_addr, 32'h100); cyc();
    drive(0, 4'b0, 0, 0, 0, 1, 0, 0, 0); #1 chk("t4_pushed", mem_addr, 32'h84); cyc();

    // T5: stall holds PC and blocks irq; register jump still acts
    drive(1, 4'b0001, 1, 0, 0, 0, 32'h600, 0, 0); #1;
    chk("t5_hold", mem_addr, 32'h84);
    chk("t5_no_irq", 32'(interrupt), 32'h0);
    cyc();
    drive(1, 4'b0, 0, 0, 1, 0, 0, 0, 32'h300); #1;
    chk("t5_pcr", mem_addr, 32'h300);
    chk("t5_flush", 32'(flush), 32'h1);
    cyc();

    // T6: underflowing return
    drive(0, 4'b0, 0, 0, 0, 1, 0, 0, 0); #1 chk("t6_reset_pc", mem_addr, 32'h0); cyc();
    chk("t6_err_set", 32'(stack_err), 32'h1);
    idle(); idle(); idle();
    chk("t6_err_sticky", 32'(stack_err), 32'h1);
    do_reset();

    // Random traffic with occasional asynchronous reset
    for (int n = 0; n < 3000; n++) begin
      al = ($urandom_range(0, 9) < 4) ? 4'($urandom()) : 4'b0;
      a0 = $urandom() & 32'hFFFF_FFFC;
      a1 = $urandom() & 32'hFFFF_FFFC;
      a2 = $urandom() & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 9) < 2), al, ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 6) == 0), a0, a1, a2);
      cyc();
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    @(negedge clk); #1;
    chk("sb_all_popped", 32'(pops), 32'(pushes));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
